// File: rtl/engine_read_write_kernel_pipe_pkg.sv
// Shared types and constants for the read/write engine kernel pipe.
// Packet, configuration, request-address and FIFO payload definitions.
package engine_read_write_kernel_pipe_pkg;

    localparam int unsigned ENGINE_PACKET_DATA_NUM_FIELDS      = 4;
    localparam int unsigned ENGINE_READ_WRITE_KERNEL_FIFO_DEPTH = 4;
    localparam int unsigned ENGINE_FIELD_W                      = 32;

    typedef enum logic [1:0] {
        SEQUENCE_INVALID = 2'd0,
        SEQUENCE_RUNNING = 2'd1,
        SEQUENCE_DONE    = 2'd2,
        SEQUENCE_IDLE    = 2'd3
    } sequence_state_e;

    typedef struct packed {
        logic [ENGINE_PACKET_DATA_NUM_FIELDS-1:0][ENGINE_FIELD_W-1:0] field;
        logic [ENGINE_PACKET_DATA_NUM_FIELDS-1:0][1:0]                state;
    } EnginePacketData;

    typedef struct packed {
        logic [5:0] amount;
        logic       direction;
    } ShiftParameters;

    typedef struct packed {
        logic [ENGINE_PACKET_DATA_NUM_FIELDS-1:0]                                    const_mask;
        logic [ENGINE_FIELD_W-1:0]                                                   const_value;
        logic [ENGINE_PACKET_DATA_NUM_FIELDS-1:0][ENGINE_PACKET_DATA_NUM_FIELDS-1:0] ops_mask;
        logic [63:0]                                                                 index_start;
        logic [63:0]                                                                 index_end;
        logic [5:0]                                                                  granularity;
        logic                                                                        direction;
        logic [3:0]                                                                  mode_cache;
        logic [7:0]                                                                  id_channel;
        logic [7:0]                                                                  id_buffer;
        logic [7:0]                                                                  burst_length;
    } ReadWriteConfigurationParameters;

    typedef struct packed {
        logic [63:0]    offset;
        ShiftParameters shift;
        logic [3:0]     mode_cache;
        logic [7:0]     id_channel;
        logic [7:0]     id_buffer;
        logic [7:0]     burst_length;
    } PacketRequestDataAddress;

    typedef struct packed {
        PacketRequestDataAddress address;
        EnginePacketData         data;
    } EngineReadWriteKernelBeat;

    // A zero burst length is meaningless downstream, so it is promoted to one.
    function automatic logic [7:0] burst_or_one(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/engine_read_write_kernel_fifo.sv
// Synchronous register FIFO; head is zero while empty.
module engine_read_write_kernel_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [7:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output T                         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q;
    logic [PTR_W-1:0]   rd_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/engine_read_write_kernel_pipe.sv
// Read/write engine kernel: field remap, address shift, elastic output buffer.
// Optional bounds check enabled by defining ENGINE_READ_WRITE_BOUNDS_CHECK_EN.
module engine_read_write_kernel_pipe
    import engine_read_write_kernel_pipe_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = ENGINE_PACKET_DATA_NUM_FIELDS,
    parameter int unsigned ADDR_FIELD = 1,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned FIFO_DEPTH = ENGINE_READ_WRITE_KERNEL_FIFO_DEPTH
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  ReadWriteConfigurationParameters config_params_in,
    input  EnginePacketData                 data_in,
    input  logic                            in_valid,
    output logic                            in_ready,
    output PacketRequestDataAddress         address_out,
    output EnginePacketData                 result_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     drop_count_out
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                            s1_valid_d, s1_valid_q;
    EnginePacketData                 s1_data_d, s1_data_q;
    ReadWriteConfigurationParameters s1_cfg_q;
    logic                            s2_valid_d, s2_valid_q;
    EngineReadWriteKernelBeat        s2_beat_d, s2_beat_q;
    EngineReadWriteKernelBeat        fifo_head;
    logic [ADDR_W-1:0]               addr_sum;
    logic [ADDR_W-1:0]               addr_shifted;
    logic                            bounds_drop;
    logic                            fifo_empty;
    logic [CNT_W-1:0]                fifo_count;
    logic [CNT_W:0]                  credits_used;
    logic                            fifo_full_unused;
    logic                            unused_cfg_bits;

    // Credits cover every beat past the input, so S1/S2 never need to stall.
    assign credits_used = {1'b0, fifo_count} + (CNT_W+1)'(s1_valid_q) + (CNT_W+1)'(s2_valid_q);
    assign in_ready     = !areset && (credits_used < (CNT_W+1)'(FIFO_DEPTH));
    assign s1_valid_d   = in_valid && in_ready;

    always_comb begin
        s1_data_d = '0;
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            s1_data_d.state[i] = SEQUENCE_INVALID;
            if (config_params_in.const_mask[i]) begin
                s1_data_d.field[i] = config_params_in.const_value;
                s1_data_d.state[i] = SEQUENCE_RUNNING;
            end else begin
                for (int unsigned j = 0; j < NUM_FIELDS; j++) begin
                    if (config_params_in.ops_mask[i][j]) begin
                        s1_data_d.field[i] = data_in.field[j];
                        s1_data_d.state[i] = data_in.state[j];
                    end
                end
            end
        end
    end

    always_comb begin
        addr_sum     = s1_cfg_q.index_start[ADDR_W-1:0] + ADDR_W'(s1_data_q.field[ADDR_FIELD]);
        addr_shifted = s1_cfg_q.direction ? (addr_sum << s1_cfg_q.granularity)
                                          : (addr_sum >> s1_cfg_q.granularity);
        s2_beat_d                      = '0;
        s2_beat_d.address.offset       = 64'(addr_shifted);
        s2_beat_d.address.shift.amount = s1_cfg_q.granularity;
        s2_beat_d.address.shift.direction = s1_cfg_q.direction;
        s2_beat_d.address.mode_cache   = s1_cfg_q.mode_cache;
        s2_beat_d.address.id_channel   = s1_cfg_q.id_channel;
        s2_beat_d.address.id_buffer    = s1_cfg_q.id_buffer;
        s2_beat_d.address.burst_length = burst_or_one(s1_cfg_q.burst_length);
        s2_beat_d.data                 = s1_data_q;
    end

    assign s2_valid_d = s1_valid_q && !bounds_drop;

`ifdef ENGINE_READ_WRITE_BOUNDS_CHECK_EN
    logic [31:0] drop_count_q;

    assign bounds_drop     = addr_sum > s1_cfg_q.index_end[ADDR_W-1:0];
    assign drop_count_out  = drop_count_q;
    assign unused_cfg_bits = ^{s1_cfg_q.const_mask, s1_cfg_q.const_value, s1_cfg_q.ops_mask};

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            drop_count_q <= '0;
        end else if (s1_valid_q && bounds_drop && (drop_count_q != '1)) begin
            drop_count_q <= drop_count_q + 32'd1;
        end
    end
`else
    assign bounds_drop     = 1'b0;
    assign drop_count_out  = '0;
    assign unused_cfg_bits = ^{s1_cfg_q.const_mask, s1_cfg_q.const_value, s1_cfg_q.ops_mask,
                               s1_cfg_q.index_end};
`endif

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_cfg_q   <= '0;
            s2_beat_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_valid_d) begin
                s1_data_q <= s1_data_d;
                s1_cfg_q  <= config_params_in;
            end
            if (s1_valid_q) begin
                s2_beat_q <= s2_beat_d;
            end
        end
    end

    engine_read_write_kernel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (EngineReadWriteKernelBeat)
    ) u_fifo (
        .clk_i   (ap_clk),
        .rst_i   (areset),
        .push_i  (s2_valid_q),
        .data_i  (s2_beat_q),
        .pop_i   (out_ready),
        .data_o  (fifo_head),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid   = !fifo_empty;
    assign address_out = fifo_head.address;
    assign result_out  = fifo_head.data;

endmodule

// File: tb/tb_engine_read_write_kernel_pipe.sv
// Scoreboard bench for engine_read_write_kernel_pipe; expectations follow
// ENGINE_READ_WRITE_BOUNDS_CHECK_EN the same way the design does.
module tb_engine_read_write_kernel_pipe;
    import engine_read_write_kernel_pipe_pkg::*;

    localparam int unsigned N     = ENGINE_PACKET_DATA_NUM_FIELDS;
    localparam int unsigned DEPTH = 4;

    logic                            ap_clk = 1'b0;
    logic                            areset = 1'b1;
    ReadWriteConfigurationParameters cfg    = '0;
    EnginePacketData                 data   = '0;
    logic                            in_valid = 1'b0;
    logic                            in_ready;
    PacketRequestDataAddress         addr;
    EnginePacketData                 res;
    logic                            out_valid;
    logic                            out_ready = 1'b0;
    logic [31:0]                     drop;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    EngineReadWriteKernelBeat sb[$];
    EngineReadWriteKernelBeat exp_b;

    engine_read_write_kernel_pipe #(
        .ADDR_FIELD (1),
        .ADDR_W     (64),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .ap_clk           (ap_clk),
        .areset           (areset),
        .config_params_in (cfg),
        .data_in          (data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .address_out      (addr),
        .result_out       (res),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .drop_count_out   (drop)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic EngineReadWriteKernelBeat model(input ReadWriteConfigurationParameters c,
                                                       input EnginePacketData d);
        EngineReadWriteKernelBeat b;
        logic [63:0] sum;
        b = '0;
        for (int i = 0; i < N; i++) begin
            if (c.const_mask[i]) begin
                b.data.field[i] = c.const_value;
                b.data.state[i] = SEQUENCE_RUNNING;
            end else begin
                for (int j = N - 1; j >= 0; j--) begin
                    if (c.ops_mask[i][j]) begin
                        b.data.field[i] = d.field[j];
                        b.data.state[i] = d.state[j];
                        break;
                    end
                end
            end
        end
        sum = c.index_start + {32'h0, b.data.field[1]};
        b.address.offset          = c.direction ? (sum << c.granularity) : (sum >> c.granularity);
        b.address.shift.amount    = c.granularity;
        b.address.shift.direction = c.direction;
        b.address.mode_cache      = c.mode_cache;
        b.address.id_channel      = c.id_channel;
        b.address.id_buffer       = c.id_buffer;
        b.address.burst_length    = (c.burst_length == 8'd0) ? 8'd1 : c.burst_length;
        return b;
    endfunction

    function automatic bit model_drop(input ReadWriteConfigurationParameters c, input EnginePacketData d);
`ifdef ENGINE_READ_WRITE_BOUNDS_CHECK_EN
        EngineReadWriteKernelBeat b;
        b = model(c, d);
        return (c.index_start + {32'h0, b.data.field[1]}) > c.index_end;
`else
        return 1'b0;
`endif
    endfunction

    function automatic ReadWriteConfigurationParameters base_cfg();
        ReadWriteConfigurationParameters c;
        c = '0;
        for (int i = 0; i < N; i++) c.ops_mask[i][i] = 1'b1;
        c.index_end    = '1;
        c.direction    = 1'b1;
        c.mode_cache   = 4'h3;
        c.id_channel   = 8'h01;
        c.id_buffer    = 8'h02;
        c.burst_length = 8'd4;
        return c;
    endfunction

    function automatic EnginePacketData gen_data(input int k);
        EnginePacketData d;
        for (int j = 0; j < N; j++) begin
            d.field[j] = 32'(k * 16 + j);
            d.state[j] = SEQUENCE_RUNNING;
        end
        return d;
    endfunction

    // Scoreboard: accepted beats queue their expected output, outputs pop in order.
    always @(negedge ap_clk) begin
        if (areset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_vec++;
                n_out++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got offset=%h with nothing expected", addr.offset);
                end else begin
                    exp_b = sb.pop_front();
                    if ({addr, res} !== exp_b) begin
                        n_err++;
                        $display("FAIL sb_beat: got %h required %h", {addr, res}, exp_b);
                    end
                end
            end
            if (in_valid && in_ready && !model_drop(cfg, data)) sb.push_back(model(cfg, data));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_beat(input ReadWriteConfigurationParameters c, input EnginePacketData d);
        bit ok = 1'b0;
        cfg = c;
        data = d;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge ap_clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready got 0 required 1 within 50 cycles");
        end
    endtask

    // Returns at the negedge where out_valid is first seen; lat counts cycles after accept.
    task automatic wait_out(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge ap_clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic stream_cycle(input int k, output bit acc);
        cfg = base_cfg();
        cfg.index_start = 64'(k) << 8;
        data = gen_data(k);
        in_valid = 1'b1;
        @(negedge ap_clk);
        acc = in_ready;
        tick();
    endtask

    task automatic test_reset();
        areset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        @(negedge ap_clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        n_vec++; if (addr !== '0) begin n_err++; $display("FAIL rst_address: got %h required 0", addr); end
        n_vec++; if (res !== '0) begin n_err++; $display("FAIL rst_result: got %h required 0", res); end
        n_vec++; if (drop !== 32'd0) begin n_err++; $display("FAIL rst_drop: got %0d required 0", drop); end
        tick();
        areset = 1'b0;
        @(negedge ap_clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
        tick();
    endtask

    task automatic test_remap_address();
        ReadWriteConfigurationParameters c;
        EnginePacketData d;
        int lat;
        c = base_cfg();
        c.const_mask = 4'b0001; c.const_value = 32'd7; c.ops_mask[1] = 4'b0100;
        c.index_start = 64'h100; c.granularity = 6'd2; c.direction = 1'b1; c.burst_length = 8'd0;
        d = gen_data(0);
        d.field[2] = 32'h10;
        out_ready = 1'b1;
        send_beat(c, d);
        wait_out(lat);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL remap_latency: got %0d required 3", lat); end
        n_vec++; if (addr.offset !== 64'h440) begin n_err++; $display("FAIL remap_offset: got %h required 440", addr.offset); end
        n_vec++; if (res.field[0] !== 32'd7) begin n_err++; $display("FAIL remap_const: got %h required 7", res.field[0]); end
        n_vec++; if (res.state[0] !== SEQUENCE_RUNNING) begin n_err++; $display("FAIL remap_const_state: got %0d required 1", res.state[0]); end
        n_vec++; if (res.field[1] !== 32'h10) begin n_err++; $display("FAIL remap_ops: got %h required 10", res.field[1]); end
        n_vec++; if (addr.burst_length !== 8'd1) begin n_err++; $display("FAIL remap_burst: got %0d required 1", addr.burst_length); end
        n_vec++; if (addr.id_channel !== 8'h01 || addr.mode_cache !== 4'h3) begin n_err++; $display("FAIL remap_ids: got ch=%h mc=%h required 01/3", addr.id_channel, addr.mode_cache); end
        tick();
    endtask

    task automatic test_shift_wrap_priority();
        ReadWriteConfigurationParameters c;
        EnginePacketData d;
        int lat;
        out_ready = 1'b1;
        c = base_cfg(); c.direction = 1'b0; c.granularity = 6'd3; c.index_start = 64'h40; c.burst_length = 8'd5;
        d = gen_data(1); d.field[1] = 32'h7;
        send_beat(c, d); wait_out(lat);
        n_vec++; if (addr.offset !== 64'h8) begin n_err++; $display("FAIL right_shift: got %h required 8", addr.offset); end
        n_vec++; if (addr.burst_length !== 8'd5) begin n_err++; $display("FAIL burst_pass: got %0d required 5", addr.burst_length); end
        tick();
        c = base_cfg(); c.index_start = '1;
        d = gen_data(2); d.field[1] = 32'h2;
        send_beat(c, d); wait_out(lat);
        n_vec++; if (addr.offset !== 64'h1) begin n_err++; $display("FAIL wrap: got %h required 1", addr.offset); end
        tick();
        c = base_cfg(); c.ops_mask[1] = 4'b0110; c.ops_mask[0] = 4'b0000;
        d = gen_data(3); d.field[1] = 32'hAA; d.field[2] = 32'h55; d.state[2] = SEQUENCE_DONE;
        send_beat(c, d); wait_out(lat);
        n_vec++; if (res.field[1] !== 32'h55) begin n_err++; $display("FAIL priority_field: got %h required 55", res.field[1]); end
        n_vec++; if (res.state[1] !== SEQUENCE_DONE) begin n_err++; $display("FAIL priority_state: got %0d required 2", res.state[1]); end
        n_vec++; if (res.field[0] !== 32'h0 || res.state[0] !== SEQUENCE_INVALID) begin n_err++; $display("FAIL no_source: got %h/%0d required 0/0", res.field[0], res.state[0]); end
        n_vec++; if (addr.offset !== 64'h55) begin n_err++; $display("FAIL priority_offset: got %h required 55", addr.offset); end
        tick();
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int start = n_out;
        bit acc;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            stream_cycle(100 + k, acc);
            if (acc) k++;
            n_vec++; if (sb.size() > DEPTH) begin n_err++; $display("FAIL bp_occupancy: got %0d required <= %0d", sb.size(), DEPTH); end
        end
        n_vec++; if (k != 4) begin n_err++; $display("FAIL bp_accepts: got %0d required 4", k); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && (k < 10 || n_out - start < 10); cyc++) begin
            if (k < 10) begin
                stream_cycle(100 + k, acc);
                if (acc) k++;
            end else begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
        n_vec++; if (n_out - start != 10) begin n_err++; $display("FAIL bp_drain: got %0d beats required 10", n_out - start); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL bp_leftover: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_push_pop_full();
        bit acc;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) stream_cycle(200 + cyc, acc);
        for (int cyc = 0; cyc < 24; cyc++) begin
            out_ready = cyc[0];
            stream_cycle(300 + cyc, acc);
            n_vec++; if (sb.size() > DEPTH) begin n_err++; $display("FAIL full_occupancy: got %0d required <= %0d", sb.size(), DEPTH); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && sb.size() != 0; cyc++) tick();
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL full_drain: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_bounds();
        ReadWriteConfigurationParameters c;
        EnginePacketData d;
        int start = n_out;
        int exp_out;
        logic [31:0] exp_drop;
`ifdef ENGINE_READ_WRITE_BOUNDS_CHECK_EN
        exp_out = 1; exp_drop = 32'd1;
`else
        exp_out = 2; exp_drop = 32'd0;
`endif
        out_ready = 1'b1;
        c = base_cfg(); c.index_end = 64'h1FF; c.index_start = 64'h1F0;
        d = gen_data(4); d.field[1] = 32'hF;
        send_beat(c, d);
        c.index_start = 64'h1F1;
        send_beat(c, d);
        repeat (6) tick();
        n_vec++; if (n_out - start != exp_out) begin n_err++; $display("FAIL bounds_out: got %0d required %0d", n_out - start, exp_out); end
        n_vec++; if (drop !== exp_drop) begin n_err++; $display("FAIL bounds_drop: got %0d required %0d", drop, exp_drop); end
    endtask

    task automatic test_reset_midstream();
        ReadWriteConfigurationParameters c;
        int lat;
        bit acc;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) stream_cycle(400 + cyc, acc);
        areset = 1'b1;
        tick();
        @(negedge ap_clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
        n_vec++; if (drop !== 32'd0) begin n_err++; $display("FAIL mid_rst_drop: got %0d required 0", drop); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_ready: got %b required 0", in_ready); end
        tick();
        areset = 1'b0;
        in_valid = 1'b0;
        @(negedge ap_clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_release: got %b required 1", in_ready); end
        tick();
        out_ready = 1'b1;
        c = base_cfg(); c.index_start = 64'h1000;
        send_beat(c, gen_data(9));
        wait_out(lat);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL mid_rst_latency: got %0d required 3", lat); end
        n_vec++; if (addr.offset !== 64'h1091) begin n_err++; $display("FAIL mid_rst_offset: got %h required 1091", addr.offset); end
        repeat (4) tick();
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL mid_rst_leftover: got %0d pending required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_remap_address();
        test_shift_wrap_priority();
        test_back_to_back();
        test_push_pop_full();
        test_bounds();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
